// File: rtl/game_state_regfile.sv
// Avalon-MM game-state register bank: software fills a shadow bank, and a commit
// copies it to the active bank on the next vertical-sync falling edge.
module game_state_regfile #(
   parameter int WORDS = 64
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic                  avl_chipselect,
   input  logic                  avl_read,
   input  logic                  avl_write,
   input  logic [5:0]            avl_address,
   input  logic [3:0]            avl_byteenable,
   input  logic [31:0]           avl_writedata,
   output logic [31:0]           avl_readdata,
   input  logic                  frame_sync,
   output logic [32*WORDS-1:0]   game_readdata,
   output logic                  commit_pending,
   output logic [15:0]           frame_count
);

   localparam int         DATA_WORDS = WORDS - 1;
   localparam logic [5:0] CTRL_ADDR  = 6'(WORDS - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ARMED = 2'd1;
   localparam logic [1:0] COPY  = 2'd2;

   logic [31:0] shadow_bank [DATA_WORDS];
   logic [31:0] active_bank [DATA_WORDS];

   logic [1:0]  state;
   logic [1:0]  state_next;
   logic        auto_commit;
   logic        vs_q;
   logic [15:0] frame_cnt;

   logic        wr_en;
   logic        rd_en;
   logic        ctrl_wr;
   logic        commit_wr;
   logic        frame_edge;

   assign wr_en      = avl_chipselect & avl_write;
   assign rd_en      = avl_chipselect & avl_read;
   assign ctrl_wr    = wr_en && (avl_address == CTRL_ADDR) && avl_byteenable[0];
   assign commit_wr  = ctrl_wr & avl_writedata[0];
   assign frame_edge = vs_q & ~frame_sync;

   // A commit request always wins over an auto-commit edge seen in the same IDLE cycle.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (commit_wr)
               state_next = ARMED;
            else if (frame_edge && auto_commit)
               state_next = COPY;
         end
         ARMED: begin
            if (frame_edge)
               state_next = COPY;
         end
         COPY:    state_next = commit_wr ? ARMED : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state       <= IDLE;
         auto_commit <= 1'b0;
         vs_q        <= 1'b0;
         frame_cnt   <= 16'h0000;
      end else begin
         state <= state_next;
         vs_q  <= frame_sync;
         if (frame_edge)
            frame_cnt <= frame_cnt + 16'd1;
         if (ctrl_wr)
            auto_commit <= avl_writedata[1];
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < DATA_WORDS; i++)
            shadow_bank[i] <= '0;
      end else if (wr_en && (avl_address != CTRL_ADDR)) begin
         for (int b = 0; b < 4; b++)
            if (avl_byteenable[b])
               shadow_bank[avl_address][8*b +: 8] <= avl_writedata[8*b +: 8];
      end
   end

   // The copy samples the shadow as it stood at the start of COPY, so a write in that cycle waits.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < DATA_WORDS; i++)
            active_bank[i] <= '0;
      end else if (state == COPY) begin
         for (int i = 0; i < DATA_WORDS; i++)
            active_bank[i] <= shadow_bank[i];
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)
         avl_readdata <= '0;
      else if (rd_en)
         avl_readdata <= (avl_address == CTRL_ADDR)
                         ? {frame_cnt, 14'b0, auto_commit, commit_pending}
                         : shadow_bank[avl_address];
   end

   for (genvar i = 0; i < DATA_WORDS; i++) begin : g_active
      assign game_readdata[32*i +: 32] = active_bank[i];
   end
   assign game_readdata[32*WORDS-1 -: 32] = {16'h0000, frame_cnt};

   assign commit_pending = (state != IDLE);
   assign frame_count    = frame_cnt;

endmodule

// File: tb/tb_game_state_regfile.sv
// Directed self-checking bench for game_state_regfile: shadow/active banking,
// commit timing, auto mode, byte lanes, frame counter wrap and reset mid-COPY.
module tb_game_state_regfile;

   logic          Clk;
   logic          Reset_n;
   logic          avl_chipselect;
   logic          avl_read;
   logic          avl_write;
   logic [5:0]    avl_address;
   logic [3:0]    avl_byteenable;
   logic [31:0]   avl_writedata;
   logic [31:0]   avl_readdata;
   logic          frame_sync;
   logic [2047:0] game_readdata;
   logic          commit_pending;
   logic [15:0]   frame_count;

   int checks = 0;
   int errors = 0;
   logic [31:0] rd;

   game_state_regfile #(.WORDS(64)) dut (
      .Clk            (Clk),
      .Reset_n        (Reset_n),
      .avl_chipselect (avl_chipselect),
      .avl_read       (avl_read),
      .avl_write      (avl_write),
      .avl_address    (avl_address),
      .avl_byteenable (avl_byteenable),
      .avl_writedata  (avl_writedata),
      .avl_readdata   (avl_readdata),
      .frame_sync     (frame_sync),
      .game_readdata  (game_readdata),
      .commit_pending (commit_pending),
      .frame_count    (frame_count)
   );

   initial Clk = 1'b0;
   always #10 Clk = ~Clk;

   function automatic logic [31:0] gw(input int i);
      return game_readdata[32*i +: 32];
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic avlWrite(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] be);
      avl_chipselect = 1'b1;
      avl_write      = 1'b1;
      avl_address    = addr;
      avl_writedata  = data;
      avl_byteenable = be;
      tick();
      avl_write      = 1'b0;
      avl_chipselect = 1'b0;
   endtask

   task automatic avlRead(input logic [5:0] addr, output logic [31:0] data);
      avl_chipselect = 1'b1;
      avl_read       = 1'b1;
      avl_address    = addr;
      tick();
      avl_read       = 1'b0;
      avl_chipselect = 1'b0;
      data           = avl_readdata;
   endtask

   // Leaves the bench inside the cycle in which the falling edge is detected.
   task automatic frameEdge();
      frame_sync = 1'b1;
      tick();
      frame_sync = 1'b0;
   endtask

   initial begin
      Reset_n        = 1'b0;
      avl_chipselect = 1'b0;
      avl_read       = 1'b0;
      avl_write      = 1'b0;
      avl_address    = '0;
      avl_byteenable = '0;
      avl_writedata  = '0;
      frame_sync     = 1'b1;
      $display("[TB] start");

      repeat (2) tick();
      checkOutput("rst_pending", 32'(commit_pending), 32'd0);
      checkOutput("rst_frame_count", 32'(frame_count), 32'd0);
      checkOutput("rst_readdata", avl_readdata, 32'd0);
      checkOutput("rst_game_zero", 32'(game_readdata == '0), 32'd1);
      frame_sync = 1'b0;
      tick();
      Reset_n = 1'b1;
      tick();
      checkOutput("post_rst_frame_count", 32'(frame_count), 32'd0);
      checkOutput("post_rst_game_zero", 32'(game_readdata == '0), 32'd1);

      avlWrite(6'd1, 32'h0000_0140, 4'hF);
      avlWrite(6'd2, 32'h0000_00F0, 4'hF);
      checkOutput("active_w1_before_commit", gw(1), 32'd0);
      avlRead(6'd1, rd);
      checkOutput("shadow_read_w1", rd, 32'h0000_0140);
      avlWrite(6'd63, 32'h0000_0001, 4'hF);
      checkOutput("pending_after_commit_wr", 32'(commit_pending), 32'd1);
      frameEdge();
      tick();
      checkOutput("copy_pending", 32'(commit_pending), 32'd1);
      checkOutput("copy_active_w1_old", gw(1), 32'd0);
      checkOutput("copy_frame_count", 32'(frame_count), 32'd1);
      tick();
      checkOutput("commit_active_w1", gw(1), 32'h0000_0140);
      checkOutput("commit_active_w2", gw(2), 32'h0000_00F0);
      checkOutput("commit_pending_cleared", 32'(commit_pending), 32'd0);

      avlWrite(6'd3, 32'hAABB_CCDD, 4'hF);
      avlWrite(6'd3, 32'h1122_3344, 4'b0101);
      avlRead(6'd3, rd);
      checkOutput("byteenable_w3", rd, 32'hAA22_CC44);

      avl_chipselect = 1'b0;
      avl_write      = 1'b1;
      avl_address    = 6'd4;
      avl_writedata  = 32'hDEAD_BEEF;
      avl_byteenable = 4'hF;
      tick();
      avl_write = 1'b0;
      avlRead(6'd4, rd);
      checkOutput("no_chipselect_w4", rd, 32'd0);

      avlWrite(6'd63, 32'h0000_0001, 4'hF);
      frameEdge();
      tick();
      checkOutput("in_copy_pending", 32'(commit_pending), 32'd1);
      avlWrite(6'd1, 32'h0000_0055, 4'hF);
      checkOutput("write_in_copy_active_old", gw(1), 32'h0000_0140);
      checkOutput("write_in_copy_idle", 32'(commit_pending), 32'd0);
      avlRead(6'd1, rd);
      checkOutput("write_in_copy_shadow", rd, 32'h0000_0055);
      avlWrite(6'd63, 32'h0000_0001, 4'hF);
      frameEdge();
      tick();
      tick();
      checkOutput("next_commit_w1", gw(1), 32'h0000_0055);
      checkOutput("frame_count_3", 32'(frame_count), 32'd3);

      Reset_n = 1'b0;
      tick();
      checkOutput("rst2_game_zero", 32'(game_readdata == '0), 32'd1);
      checkOutput("rst2_frame_count", 32'(frame_count), 32'd0);
      Reset_n = 1'b1;
      tick();

      avlWrite(6'd63, 32'h0000_0002, 4'hF);
      avlWrite(6'd8, 32'h0000_003F, 4'hF);
      checkOutput("auto_not_armed", 32'(commit_pending), 32'd0);
      frameEdge();
      tick();
      checkOutput("auto_copy_pending", 32'(commit_pending), 32'd1);
      tick();
      checkOutput("auto_active_w8", gw(8), 32'h0000_003F);
      frameEdge();
      tick();
      tick();
      frameEdge();
      tick();
      tick();
      checkOutput("auto_frame_count", 32'(frame_count), 32'd3);
      avlRead(6'd63, rd);
      checkOutput("ctrl_read", rd, 32'h0003_0002);
      checkOutput("game_top_word", gw(63), 32'h0000_0003);

      avlWrite(6'd63, 32'h0000_0000, 4'hF);
      avlWrite(6'd5, 32'h0000_0077, 4'hF);
      frame_sync = 1'b1;
      tick();
      frame_sync = 1'b0;
      avlWrite(6'd63, 32'h0000_0001, 4'hF);
      checkOutput("edge_and_commit_armed", 32'(commit_pending), 32'd1);
      tick();
      checkOutput("edge_and_commit_no_copy", gw(5), 32'd0);
      checkOutput("edge_and_commit_still_armed", 32'(commit_pending), 32'd1);
      frameEdge();
      tick();
      tick();
      checkOutput("armed_copy_w5", gw(5), 32'h0000_0077);
      checkOutput("frame_count_5", 32'(frame_count), 32'd5);

      force dut.frame_cnt = 16'hFFFF;
      #1;
      release dut.frame_cnt;
      checkOutput("preload_ffff", 32'(frame_count), 32'h0000_FFFF);
      avlWrite(6'd9, 32'h0000_0099, 4'hF);
      avlWrite(6'd63, 32'h0000_0001, 4'hF);
      frameEdge();
      tick();
      checkOutput("wrap_frame_count", 32'(frame_count), 32'd0);
      checkOutput("wrap_in_copy", 32'(commit_pending), 32'd1);
      Reset_n = 1'b0;
      #1;
      checkOutput("rst_copy_pending", 32'(commit_pending), 32'd0);
      checkOutput("rst_copy_game_zero", 32'(game_readdata == '0), 32'd1);
      tick();
      checkOutput("rst_copy_w9", gw(9), 32'd0);
      Reset_n = 1'b1;
      tick();
      tick();
      checkOutput("rst_copy_stays_zero", 32'(game_readdata == '0), 32'd1);
      avlRead(6'd63, rd);
      checkOutput("rst_copy_ctrl_read", rd, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
